// File: rtl/tanh_backward_pkg.sv
// Shared types and constants for the tanh backward-pass block.
package tanh_backward_pkg;

    // Default geometry of the block.
    localparam int DEF_DATA_WIDTH = 11;
    localparam int DEF_SA_LENGTH  = 256;
    localparam int DEF_S          = 7;
    localparam int DEF_LANES      = 16;

    // Number of compute cycles per vector and the fixed-point encoding of 1.0.
    localparam int NUM_CHUNKS = DEF_SA_LENGTH / DEF_LANES;
    localparam int ONE        = 2 ** DEF_S;

    // Control states: wait for a vector, sweep the chunks, hold the result.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/tanh_grad_lane.sv
// One element of the tanh derivative: dx = g * (1 - y^2), in fixed point.
// Purely combinational; the top instantiates one of these per lane.
module tanh_grad_lane #(
    parameter int DATA_WIDTH = 11,
    parameter int S          = 7
) (
    input  logic signed [DATA_WIDTH-1:0] y,
    input  logic signed [DATA_WIDTH-1:0] g,
    output logic signed [DATA_WIDTH-1:0] dx
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [PW-1:0] ONE_W = PW'(1) << S;
    localparam logic signed [PW-1:0] MAX_W = PW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] MIN_W = ~MAX_W;

    logic signed [PW-1:0] y_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] yy;
    logic signed [PW-1:0] sq;
    logic signed [PW-1:0] diff;
    logic signed [PW-1:0] d;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    // Operands are sign-extended up front so every product is formed at full width.
    assign y_ext = {{DATA_WIDTH{y[DATA_WIDTH-1]}}, y};
    assign g_ext = {{DATA_WIDTH{g[DATA_WIDTH-1]}}, g};

    // y^2 rescaled to S fractional bits; y = -2**(W-1) squares to well above 1.0.
    assign yy = y_ext * y_ext;
    assign sq = yy >>> S;

    // 1 - y^2 cannot legitimately go negative; out-of-range y clamps to zero slope.
    assign diff = ONE_W - sq;
    assign d    = diff[PW-1] ? '0 : diff;

    // Floor shift back to S fractional bits.
    assign prod    = g_ext * d;
    assign shifted = prod >>> S;

    // Saturate into the output word range.
    always_comb begin
        if (shifted > MAX_W) begin
            dx = MAX_W[DATA_WIDTH-1:0];
        end else if (shifted < MIN_W) begin
            dx = MIN_W[DATA_WIDTH-1:0];
        end else begin
            dx = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/tanh_backward.sv
// Tanh backward pass over a whole vector: captures y and g, then produces
// dx LANES elements per cycle and holds the result until it is consumed.
module tanh_backward
    import tanh_backward_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SA_LENGTH  = DEF_SA_LENGTH,
    parameter int S          = DEF_S,
    parameter int LANES      = DEF_LANES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] y  [SA_LENGTH],
    input  logic signed [DATA_WIDTH-1:0] g  [SA_LENGTH],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] dx [SA_LENGTH],
    output logic                         busy
);

    localparam int N_CHUNKS = SA_LENGTH / LANES;
    localparam int CW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int IW       = $clog2(SA_LENGTH);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(N_CHUNKS - 1);

    // A vector must split into whole chunks.
    if (SA_LENGTH % LANES != 0) begin : g_bad_geometry
        $error("tanh_backward: SA_LENGTH must be a multiple of LANES");
    end

    state_t state;
    state_t state_next;
    logic   accept;
    logic   compute;

    logic [CW-1:0] chunk;

    logic signed [DATA_WIDTH-1:0] y_buf [SA_LENGTH];
    logic signed [DATA_WIDTH-1:0] g_buf [SA_LENGTH];

    logic [IW-1:0]                lane_idx [LANES];
    logic signed [DATA_WIDTH-1:0] lane_dx  [LANES];

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_next = state;
        accept     = 1'b0;
        compute    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                busy    = 1'b1;
                compute = 1'b1;
                if (chunk == LAST_CHUNK) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Chunk counter: cleared on accept, advanced once per compute cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chunk <= '0;
        end else if (accept) begin
            chunk <= '0;
        end else if (compute) begin
            chunk <= chunk + 1'b1;
        end
    end

    // Operand capture; later changes on y and g cannot reach the result.
    always_ff @(posedge clk) begin
        // NOTE: the operand buffers are data storage, always written before use, so they carry no reset.
        if (accept) begin
            for (int i = 0; i < SA_LENGTH; i++) begin
                y_buf[i] <= y[i];
                g_buf[i] <= g[i];
            end
        end
    end

    // Lane array: lane l handles element chunk*LANES + l.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = IW'(int'(chunk) * LANES + l);

        tanh_grad_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .S          (S)
        ) u_lane (
            .y  (y_buf[lane_idx[l]]),
            .g  (g_buf[lane_idx[l]]),
            .dx (lane_dx[l])
        );
    end

    // Result register: one chunk written per compute cycle, untouched elsewhere.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SA_LENGTH; i++) begin
                dx[i] <= '0;
            end
        end else if (compute) begin
            for (int l = 0; l < LANES; l++) begin
                dx[lane_idx[l]] <= lane_dx[l];
            end
        end
    end

endmodule

// File: tb/tb_tanh_backward.sv
// Directed bench for tanh_backward at default geometry.
module tb_tanh_backward;

    localparam int DW = 11;
    localparam int SA = 256;
    localparam int LN = 16;
    localparam int NC = SA / LN;

    typedef logic signed [DW-1:0] vec_t [SA];

    logic  clk;
    logic  rst_n;
    logic  in_valid;
    logic  in_ready;
    vec_t  y;
    vec_t  g;
    logic  out_valid;
    logic  out_ready;
    vec_t  dx;
    logic  busy;

    int checks;
    int failures;

    tanh_backward dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dx        (dx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference for one element.
    function automatic logic signed [DW-1:0] model(input int yv, input int gv);
        int sq;
        int d;
        int r;
        sq = (yv * yv) >>> 7;
        d  = 128 - sq;
        if (d < 0) d = 0;
        r = (gv * d) >>> 7;
        if (r > 1023)  r = 1023;
        if (r < -1024) r = -1024;
        return DW'(r);
    endfunction

    // Number of dx elements differing from exp; first differing index in first.
    function automatic int dx_errs(input vec_t exp, output int first);
        int n;
        n     = 0;
        first = -1;
        for (int i = 0; i < SA; i++) begin
            if (dx[i] !== exp[i]) begin
                if (first < 0) first = i;
                n++;
            end
        end
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept the current y/g and count edges until out_valid (bounded).
    task automatic run_vector(input bit keep_valid, input bit scramble, output int lat);
        in_valid = 1'b1;
        step();
        if (!keep_valid) in_valid = 1'b0;
        if (scramble) begin
            for (int i = 0; i < SA; i++) begin
                y[i] = DW'($urandom_range(0, 2047));
                g[i] = DW'($urandom_range(0, 2047));
            end
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        vec_t zero;
        int   first;
        int   n;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b expected 1 0 0",
                     in_ready, out_valid, busy);
        end
        for (int i = 0; i < SA; i++) zero[i] = '0;
        n = dx_errs(zero, first);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL reset_dx: %0d elements nonzero, dx[%0d]=%0d expected 0", n, first, dx[first]);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_uniform();
        vec_t exp;
        int   lat;
        int   first;
        int   n;
        for (int i = 0; i < SA; i++) begin
            y[i]   = 11'sd64;
            g[i]   = 11'sd128;
            exp[i] = 11'sd96;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL uniform_ready: in_ready=%b expected 1", in_ready);
        end
        run_vector(1'b0, 1'b0, lat);
        checks++;
        if (lat !== NC) begin
            failures++;
            $display("FAIL uniform_latency: got %0d cycles expected %0d", lat, NC);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL uniform_busy: busy=%b in_ready=%b expected 1 0", busy, in_ready);
        end
        n = dx_errs(exp, first);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL uniform_dx: %0d wrong, dx[%0d]=%0d expected %0d", n, first, dx[first], exp[first]);
        end
        consume();
    endtask

    task automatic test_directed();
        int   ty [5] = '{128, 0, -1024, -64, 64};
        int   tg [5] = '{77, -100, 1023, -128, 128};
        int   te [5] = '{0, -100, 0, -96, 96};
        vec_t exp;
        int   lat;
        int   first;
        int   n;
        for (int i = 0; i < SA; i++) begin
            y[i]   = DW'(ty[i % 5]);
            g[i]   = DW'(tg[i % 5]);
            exp[i] = DW'(te[i % 5]);
        end
        // in_valid stays high and y/g are scrambled during compute: both must be ignored.
        run_vector(1'b1, 1'b1, lat);
        in_valid = 1'b0;
        checks++;
        if (lat !== NC) begin
            failures++;
            $display("FAIL directed_latency: got %0d cycles expected %0d", lat, NC);
        end
        n = dx_errs(exp, first);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL directed_dx: %0d wrong, dx[%0d]=%0d expected %0d", n, first, dx[first], exp[first]);
        end
        consume();
    endtask

    task automatic test_hold();
        vec_t exp;
        int   lat;
        int   first;
        int   n;
        int   bad;
        for (int i = 0; i < SA; i++) begin
            y[i]   = '0;
            g[i]   = DW'(i - 128);
            exp[i] = DW'(i - 128);
        end
        out_ready = 1'b0;
        run_vector(1'b0, 1'b0, lat);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            step();
            n = dx_errs(exp, first);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || n != 0) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_stable: %0d of 10 cycles unstable (out_valid=%b in_ready=%b)",
                     bad, out_valid, in_ready);
        end
        n = dx_errs(exp, first);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL hold_dx: %0d wrong, dx[%0d]=%0d expected %0d", n, first, dx[first], exp[first]);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b busy=%b expected 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        vec_t zero;
        vec_t exp;
        int   lat;
        int   first;
        int   n;
        int   seen;
        for (int i = 0; i < SA; i++) begin
            y[i]    = 11'sd64;
            g[i]    = 11'sd128;
            zero[i] = '0;
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_flags: in_ready=%b busy=%b out_valid=%b expected 1 0 0",
                     in_ready, busy, out_valid);
        end
        n = dx_errs(zero, first);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL midreset_dx: %0d nonzero, dx[%0d]=%0d expected 0", n, first, dx[first]);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        out_ready = 1'b0;
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midreset_no_output: out_valid high %0d cycles expected 0", seen);
        end
        for (int i = 0; i < SA; i++) begin
            y[i]   = '0;
            g[i]   = -11'sd100;
            exp[i] = -11'sd100;
        end
        run_vector(1'b0, 1'b0, lat);
        n = dx_errs(exp, first);
        checks++;
        if (lat !== NC || n != 0) begin
            failures++;
            $display("FAIL midreset_recover: latency=%0d expected %0d, %0d wrong dx[%0d]=%0d expected %0d",
                     lat, NC, n, first, dx[first], exp[first]);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        vec_t exp_arr [3];
        int   pushed;
        int   received;
        int   cyc;
        int   last_cyc;
        int   first;
        int   n;
        pushed   = 0;
        received = 0;
        cyc      = 0;
        last_cyc = -1;
        out_ready = 1'b1;
        while (received < 3 && cyc < 200) begin
            if (out_valid === 1'b1) begin
                n = dx_errs(exp_arr[received], first);
                checks++;
                if (n != 0) begin
                    failures++;
                    $display("FAIL b2b_dx[%0d]: %0d wrong, dx[%0d]=%0d expected %0d",
                             received, n, first, dx[first], exp_arr[received][first]);
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != NC + 2) begin
                        failures++;
                        $display("FAIL b2b_period[%0d]: got %0d cycles expected %0d",
                                 received, cyc - last_cyc, NC + 2);
                    end
                end
                last_cyc = cyc;
                received++;
            end
            if (in_ready === 1'b1) begin
                if (pushed < 3) begin
                    for (int i = 0; i < SA; i++) begin
                        y[i] = DW'($urandom_range(0, 2047));
                        g[i] = DW'($urandom_range(0, 2047));
                        exp_arr[pushed][i] = model(int'(y[i]), int'(g[i]));
                    end
                    pushed++;
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (received != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d results expected 3", received);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < SA; i++) begin
            y[i] = '0;
            g[i] = '0;
        end
        step();
        test_reset();
        test_uniform();
        test_directed();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
